// File: rtl/ws2812_pkg.sv
// Shared types and constants for the WS2812B frame scheduler and its pixel buffer.
package ws2812_pkg;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } grb_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    LATCH
  } sched_state_t;

  localparam int unsigned WS2812_LATCH_US = 50;
  localparam int unsigned BUSY_TIMEOUT    = 4;
  localparam int unsigned BUSY_CNT_W      = $clog2(BUSY_TIMEOUT);

endpackage

// File: rtl/ws2812_pixel_ram.sv
// Simple dual-port pixel buffer: one write port, one registered read-first read port.
module ws2812_pixel_ram #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 24,
  parameter int unsigned AW    = 3
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  // Sized to the full address space so every address decodes; DEPTH bounds writes.
  logic [WIDTH-1:0] mem_q [2**AW] = '{default: '0};
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i && (32'(waddr_i) < DEPTH)) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ws2812_frame_sched.sv
// Frame scheduler: walks the pixel buffer, hands each GRB word to the serializer
// through a start/busy handshake, then holds the chain's latch gap.
module ws2812_frame_sched
  import ws2812_pkg::*;
#(
  parameter int unsigned NUM_LEDS     = 8,
  parameter int unsigned LATCH_CYCLES = 3000,
  parameter int unsigned ADDR_W       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic              CLOCK_50,
  input  logic              KEY0,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_grb,
  input  logic              frame_go,
  input  logic              auto_refresh,
  output logic [23:0]       tx_grb,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              frame_busy,
  output logic              frame_done,
  output logic [ADDR_W-1:0] led_idx
);

  localparam int unsigned LATCH_W = $clog2(LATCH_CYCLES + 1);
  localparam logic [LATCH_W-1:0]    LATCH_LAST = LATCH_W'(LATCH_CYCLES - 1);
  localparam logic [BUSY_CNT_W-1:0] BUSY_LAST  = BUSY_CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [ADDR_W-1:0]     LAST_IDX   = ADDR_W'(NUM_LEDS - 1);

  sched_state_t          state_q, state_d;
  logic [ADDR_W-1:0]     idx_q, idx_d;
  logic [LATCH_W-1:0]    lcnt_q, lcnt_d;
  logic [BUSY_CNT_W-1:0] bcnt_q, bcnt_d;
  logic                  pend_q, pend_d;
  logic                  done_q, done_d;
  grb_t                  grb_q;
  logic [23:0]           rdata;
  logic                  restart;
  logic                  start_frame;
  logic                  word_done;

  // Read address follows the next index so the word is ready during LOAD.
  ws2812_pixel_ram #(
    .DEPTH (NUM_LEDS),
    .WIDTH (24),
    .AW    (ADDR_W)
  ) u_ram (
    .clk_i   (CLOCK_50),
    .we_i    (wr_en),
    .waddr_i (wr_addr),
    .wdata_i (wr_grb),
    .raddr_i (idx_d),
    .rdata_o (rdata)
  );

  assign restart    = frame_go | pend_q | auto_refresh;
  assign frame_busy = (state_q != IDLE);
  assign frame_done = done_q;
  assign tx_grb     = grb_q;
  assign led_idx    = idx_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    lcnt_d      = lcnt_q;
    bcnt_d      = bcnt_q;
    pend_d      = pend_q;
    done_d      = 1'b0;
    tx_start    = 1'b0;
    start_frame = 1'b0;
    word_done   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (restart) start_frame = 1'b1;
      end
      LOAD: begin
        state_d = START;
      end
      START: begin
        tx_start = 1'b1;
        bcnt_d   = '0;
        state_d  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // A serializer that never answers must not stall the chain.
        if (tx_busy)                 state_d   = WAIT_DONE;
        else if (bcnt_q == BUSY_LAST) word_done = 1'b1;
        else                         bcnt_d    = bcnt_q + 1'b1;
      end
      WAIT_DONE: begin
        if (!tx_busy) word_done = 1'b1;
      end
      LATCH: begin
        if (lcnt_q == LATCH_LAST) begin
          done_d = 1'b1;
          if (restart) start_frame = 1'b1;
          else         state_d     = IDLE;
        end else begin
          lcnt_d = lcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (word_done) begin
      if (idx_q == LAST_IDX) begin
        state_d = LATCH;
        lcnt_d  = '0;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = LOAD;
      end
    end

    if (start_frame) begin
      state_d = LOAD;
      idx_d   = '0;
      pend_d  = 1'b0;
    end else if (frame_go && frame_busy) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      state_q <= IDLE;
      idx_q   <= '0;
      lcnt_q  <= '0;
      bcnt_q  <= '0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      grb_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lcnt_q  <= lcnt_d;
      bcnt_q  <= bcnt_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      if (state_q == LOAD) grb_q <= rdata;
    end
  end

endmodule

// File: tb/tb_ws2812_frame_sched.sv
// Scoreboard bench for ws2812_frame_sched with a behavioural serializer model.
module tb_ws2812_frame_sched;

  localparam int N        = 4;
  localparam int L        = 16;
  localparam int AW       = 3;
  localparam int BUSY_LEN = 10;
  localparam int TMO      = 4;

  logic          CLOCK_50 = 1'b0;
  logic          KEY0 = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [23:0]   wr_grb = '0;
  logic          frame_go = 1'b0;
  logic          auto_refresh = 1'b0;
  logic          tx_busy = 1'b0;
  logic [23:0]   tx_grb;
  logic          tx_start;
  logic          frame_busy;
  logic          frame_done;
  logic [AW-1:0] led_idx;

  ws2812_frame_sched #(
    .NUM_LEDS     (N),
    .LATCH_CYCLES (L),
    .ADDR_W       (AW)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .KEY0         (KEY0),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_grb       (wr_grb),
    .frame_go     (frame_go),
    .auto_refresh (auto_refresh),
    .tx_grb       (tx_grb),
    .tx_start     (tx_start),
    .tx_busy      (tx_busy),
    .frame_busy   (frame_busy),
    .frame_done   (frame_done),
    .led_idx      (led_idx)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef enum {A_GO, A_DONE, A_WORD} anchor_e;
  typedef struct {
    bit          is_done;
    logic [23:0] grb;
    int          idx;
    anchor_e     anc;
    bit          restart;
  } exp_t;

  exp_t        q[$];
  logic [23:0] pix [N];
  int          cyc = 0;
  int          go_cyc = 0;
  int          last_c = 0;
  int          last_done = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  int          rem = 0;
  bit          ser_present = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Serializer: busy for BUSY_LEN cycles starting the cycle after tx_start.
  always @(negedge CLOCK_50) begin
    if (rem > 0) begin
      tx_busy = 1'b1;
      rem--;
    end else begin
      tx_busy = 1'b0;
    end
    if (tx_start && ser_present) rem = BUSY_LEN;
  end

  // Monitor: every word hand-off and frame end is matched against the queue.
  always @(negedge CLOCK_50) begin
    exp_t e;
    if (KEY0 && frame_done) begin
      chk("done_expected", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("done_kind", 32'(e.is_done), 32'd1);
        chk("done_time", cyc, last_c + L + 1);
        chk("done_busy", 32'(frame_busy), 32'(e.restart));
        last_done = cyc;
      end
    end
    if (KEY0 && tx_start) begin
      chk("start_expected", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("start_kind", 32'(e.is_done), 32'd0);
        chk("tx_grb", 32'(tx_grb), 32'(e.grb));
        chk("led_idx", 32'(led_idx), e.idx);
        case (e.anc)
          A_GO:    chk("start_time_go", cyc, go_cyc + 2);
          A_DONE:  chk("start_time_restart", cyc, last_done + 1);
          default: chk("start_time_gap", cyc, last_c + 2);
        endcase
        last_c = ser_present ? cyc + BUSY_LEN + 1 : cyc + TMO;
      end
    end
  end

  task automatic tick();
    @(negedge CLOCK_50);
  endtask

  task automatic write_px(input logic [AW-1:0] a, input logic [23:0] d);
    @(negedge CLOCK_50);
    wr_en = 1'b1; wr_addr = a; wr_grb = d;
    @(negedge CLOCK_50);
    wr_en = 1'b0;
    if (int'(a) < N) pix[a] = d;
  endtask

  task automatic push_frame(input anchor_e first, input bit restart, input int npix);
    exp_t e;
    for (int i = 0; i < npix; i++) begin
      e.is_done = 1'b0; e.grb = pix[i]; e.idx = i;
      e.anc = (i == 0) ? first : A_WORD; e.restart = 1'b0;
      q.push_back(e);
    end
    if (npix == N) begin
      e.is_done = 1'b1; e.grb = '0; e.idx = 0; e.anc = A_WORD; e.restart = restart;
      q.push_back(e);
    end
  endtask

  task automatic pulse_go(input bit anchor);
    @(negedge CLOCK_50);
    frame_go = 1'b1;
    if (anchor) go_cyc = cyc;
    @(negedge CLOCK_50);
    frame_go = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk(name, q.size(), 0);
    q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tx_grb"}, 32'(tx_grb), 32'd0);
    chk({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    chk({tag, "_frame_busy"}, 32'(frame_busy), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_led_idx"}, 32'(led_idx), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int drops;
    logic [23:0] v;
    for (int i = 0; i < N; i++) pix[i] = '0;
    #3;
    check_reset_outputs("reset");
    repeat (3) tick();
    KEY0 = 1'b1;
    tick();

    // Basic frame with fixed colours.
    write_px(0, 24'h00FF00);
    write_px(1, 24'hFF0000);
    write_px(2, 24'h0000FF);
    write_px(3, 24'h123456);
    push_frame(A_GO, 1'b0, N);
    pulse_go(1'b1);
    drain("basic_frame", 500);
    tick();
    chk("basic_idle", 32'(frame_busy), 32'd0);

    // Three requests during a frame collapse into one extra frame.
    push_frame(A_GO, 1'b1, N);
    push_frame(A_DONE, 1'b0, N);
    pulse_go(1'b1);
    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(4, 12)) tick();
      pulse_go(1'b0);
    end
    drain("pending_frames", 800);
    repeat (60) tick();
    chk("pending_no_third", 32'(frame_busy), 32'd0);

    // Auto refresh: back-to-back frames, then stop after the current one.
    push_frame(A_GO, 1'b1, N);
    push_frame(A_DONE, 1'b1, N);
    push_frame(A_DONE, 1'b0, N);
    @(negedge CLOCK_50);
    auto_refresh = 1'b1;
    go_cyc = cyc;
    drops = 0;
    n = 0;
    while (q.size() > 3 && n < 1000) begin
      tick();
      if (!frame_busy) drops++;
      n++;
    end
    auto_refresh = 1'b0;
    chk("auto_busy_drops", drops, 0);
    drain("auto_frames", 500);
    repeat (40) tick();
    chk("auto_stopped", 32'(frame_busy), 32'd0);

    // Writes during a frame: unloaded index shows now, loaded index next frame.
    push_frame(A_GO, 1'b0, N);
    q[3].grb = 24'hABCDEF;
    pulse_go(1'b1);
    n = 0;
    while (q.size() > 3 && n < 200) begin
      tick();
      n++;
    end
    v = 24'($urandom);
    write_px(3'd3, 24'hABCDEF);
    write_px(3'd0, v);
    write_px(3'd5, 24'($urandom));
    drain("midframe_write", 500);
    push_frame(A_GO, 1'b0, N);
    pulse_go(1'b1);
    drain("next_frame_write", 500);

    // Serializer absent: every word advances on the busy timeout.
    ser_present = 1'b0;
    push_frame(A_GO, 1'b0, N);
    pulse_go(1'b1);
    drain("timeout_frame", 500);
    ser_present = 1'b1;

    // Asynchronous reset while pixel 2 is being shifted.
    push_frame(A_GO, 1'b0, 3);
    pulse_go(1'b1);
    drain("pre_reset_pixels", 300);
    repeat (3) tick();
    @(posedge CLOCK_50);
    #2;
    KEY0 = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    repeat (15) tick();
    KEY0 = 1'b1;
    tick();
    chk("post_reset_idle", 32'(frame_busy), 32'd0);
    push_frame(A_GO, 1'b0, N);
    pulse_go(1'b1);
    drain("post_reset_frame", 500);

    // Randomised pixels, serializer presence and stray writes.
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < N; i++) write_px(AW'(i), 24'($urandom));
      write_px(AW'($urandom_range(4, 7)), 24'($urandom));
      ser_present = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 5)) tick();
      push_frame(A_GO, 1'b0, N);
      pulse_go(1'b1);
      drain("random_frame", 500);
      ser_present = 1'b1;
      repeat (12) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
